// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit queue.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_BUSY_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_queue_state_t;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level flags and an overflow pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             push_s;
    logic             pop_s;

    // Full is the registered flag, so a push while full is refused even if a pop lands this cycle.
    always_comb begin
        push_s     = wr_en && !full_q;
        pop_s      = rd_en && !empty_q;
        wr_ptr_d   = wr_ptr_q + (push_s ? AW'(1) : AW'(0));
        rd_ptr_d   = rd_ptr_q + (pop_s ? AW'(1) : AW'(0));
        level_d    = level_q + (push_s ? LW'(1) : LW'(0)) - (pop_s ? LW'(1) : LW'(0));
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == LW'(0));
        overflow_d = wr_en && full_q;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign full       = full_q;
    assign empty      = empty_q;
    assign empty_next = rst ? 1'b1 : empty_d;
    assign level      = level_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue feeding a UART: buffers bytes and drives the en/data/busy handshake.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
    parameter int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overflow,
    output logic                   timeout,
    output logic                   tx_idle,
    output logic                   uart_tx_en,
    output logic [UART_DATA_W-1:0] uart_tx_data,
    input  logic                   uart_tx_busy
);

    localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    tx_queue_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_en_q, tx_en_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   timeout_q, timeout_d;
    logic                   tx_idle_q, tx_idle_d;
    logic                   pop_s;
    logic [UART_DATA_W-1:0] head_s;
    logic                   empty_next_s;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop_s),
        .rd_data    (head_s),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (empty_next_s),
        .level      (fifo_level),
        .overflow   (overflow)
    );

    // The strobe is raised on the same edge that enters LAUNCH, so it is high exactly while in LAUNCH.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        timeout_d = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_s     = 1'b1;
                    tx_data_d = head_s;
                    tx_en_d   = 1'b1;
                    state_d   = LAUNCH;
                end else begin
                    state_d   = IDLE;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 2)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tx_idle_d = empty_next_s && (state_d == IDLE);
    end

    // FSM and output registers; a reset does not reach into the UART itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            timeout_q <= 1'b0;
            tx_idle_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
            tx_idle_q <= tx_idle_d;
        end
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign timeout      = timeout_q;
    assign tx_idle      = tx_idle_q;

endmodule
